// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up-counter with prescaled tick, checked load, and a
// multiplexed display scanner for a 7-segment decoder. Updates on falling clk.
module bcd_scan_counter #(
  parameter int TICK_DIV = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic        dvalid,
  output logic [3:0]  dsel,
  output logic [15:0] count,
  output logic        carry,
  output logic        err
);

  localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);
  localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] pre;
  logic [15:0] scan_cnt;
  logic [1:0]  idx;

  logic        load_ok;
  logic [15:0] count_inc;
  logic        inc_c;
  logic [1:0]  msd;
  logic [3:0]  cur_digit;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple BCD increment; inc_c left high means every digit was 9.
  always_comb begin
    count_inc = count;
    inc_c     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_c) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (count[4*i +: 4] != 4'd0) msd = 2'(i);
    end
  end

  always_comb begin
    case (idx)
      2'd0:    cur_digit = count[3:0];
      2'd1:    cur_digit = count[7:4];
      2'd2:    cur_digit = count[11:8];
      default: cur_digit = count[15:12];
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= 16'h0000;
      pre   <= 16'd0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (clr) begin
        count <= 16'h0000;
        pre   <= 16'd0;
        err   <= 1'b0;
      end else if (load) begin
        pre <= 16'd0;
        if (load_ok) count <= load_val;
        else         err   <= 1'b1;
      end else if (run) begin
        if (pre == TICK_MAX) begin
          pre   <= 16'd0;
          count <= count_inc;
          carry <= inc_c;
        end else begin
          pre <= pre + 16'd1;
        end
      end
    end
  end

  // The scanner free-runs regardless of run/clr/load so the display never stalls.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= 16'd0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= 16'd0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      digit  <= 4'd0;
      dsel   <= 4'b1110;
      dvalid <= 1'b1;
    end else begin
      digit  <= cur_digit;
      dsel   <= ~(4'b0001 << idx);
      dvalid <= !blank_lz || (idx <= msd);
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: inputs change on rising clk,
// outputs are sampled on rising clk, half a cycle after the DUT's falling edge.
module tb_bcd_scan_counter;

  typedef struct packed {
    logic [3:0] dsel;
    logic [3:0] digit;
    logic       dvalid;
    logic       chk_digit;
  } scan_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit;
  logic        dvalid;
  logic [3:0]  dsel;
  logic [15:0] count;
  logic        carry;
  logic        err;

  int passed = 0;
  int total = 0;
  int carry_seen = 0;

  logic [15:0] cnt_q[$];
  scan_exp_t   scan_q[$];

  bcd_scan_counter #(.TICK_DIV(10), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .digit(digit),
    .dvalid(dvalid), .dsel(dsel), .count(count), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (carry === 1'b1) carry_seen++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    @(posedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(posedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    total++; if (count !== 16'h0000) $display("FAIL reset_count: got %h want 0000", count); else passed++;
    total++; if (dsel !== 4'b1110) $display("FAIL reset_dsel: got %b want 1110", dsel); else passed++;
    total++; if (digit !== 4'd0) $display("FAIL reset_digit: got %h want 0", digit); else passed++;
    total++; if (dvalid !== 1'b1) $display("FAIL reset_dvalid: got %b want 1", dvalid); else passed++;
    total++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_count;
    logic [15:0] e;
    pulse_clr();
    carry_seen = 0;
    cnt_q.push_back(16'h0010);
    run = 1'b1;
    repeat (100) @(posedge clk);
    run = 1'b0;
    e = cnt_q.pop_front();
    total++; if (count !== e) $display("FAIL count_100clk: got %h want %h", count, e); else passed++;
    total++; if (carry_seen !== 0) $display("FAIL count_no_carry: got %0d pulses want 0", carry_seen); else passed++;
  endtask

  task automatic test_wrap;
    logic [15:0] e;
    pulse_load(16'h9998);
    cnt_q.push_back(16'h9999);
    cnt_q.push_back(16'h0000);
    carry_seen = 0;
    run = 1'b1;
    repeat (10) @(posedge clk);
    e = cnt_q.pop_front();
    total++; if (count !== e) $display("FAIL wrap_first_tick: got %h want %h", count, e); else passed++;
    total++; if (carry !== 1'b0) $display("FAIL wrap_carry_early: got %b want 0", carry); else passed++;
    repeat (10) @(posedge clk);
    e = cnt_q.pop_front();
    total++; if (count !== e) $display("FAIL wrap_to_zero: got %h want %h", count, e); else passed++;
    total++; if (carry !== 1'b1) $display("FAIL wrap_carry: got %b want 1", carry); else passed++;
    @(posedge clk);
    run = 1'b0;
    total++; if (carry !== 1'b0) $display("FAIL wrap_carry_drop: got %b want 0", carry); else passed++;
    total++; if (carry_seen !== 1) $display("FAIL wrap_carry_pulses: got %0d want 1", carry_seen); else passed++;
  endtask

  task automatic test_bad_load;
    pulse_load(16'h0567);
    total++; if (count !== 16'h0567) $display("FAIL load_valid: got %h want 0567", count); else passed++;
    total++; if (err !== 1'b0) $display("FAIL load_valid_err: got %b want 0", err); else passed++;
    pulse_load(16'h12A4);
    total++; if (count !== 16'h0567) $display("FAIL load_bad_count: got %h want 0567", count); else passed++;
    total++; if (err !== 1'b1) $display("FAIL load_bad_err: got %b want 1", err); else passed++;
    pulse_load(16'h0100);
    total++; if (count !== 16'h0100) $display("FAIL load_after_err: got %h want 0100", count); else passed++;
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
    pulse_clr();
    total++; if (count !== 16'h0000) $display("FAIL clr_count: got %h want 0000", count); else passed++;
    total++; if (err !== 1'b0) $display("FAIL clr_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_priority;
    pulse_load(16'h0777);
    load_val = 16'h0042;
    load = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    load = 1'b0;
    clr = 1'b0;
    total++; if (count !== 16'h0000) $display("FAIL clr_over_load: got %h want 0000", count); else passed++;
  endtask

  task automatic test_scan;
    logic [3:0] prev;
    bit found;
    scan_exp_t e;
    scan_exp_t tbl[4];
    tbl[0] = '{dsel: 4'b1110, digit: 4'd2, dvalid: 1'b1, chk_digit: 1'b1};
    tbl[1] = '{dsel: 4'b1101, digit: 4'd4, dvalid: 1'b1, chk_digit: 1'b1};
    tbl[2] = '{dsel: 4'b1011, digit: 4'd0, dvalid: 1'b0, chk_digit: 1'b0};
    tbl[3] = '{dsel: 4'b0111, digit: 4'd0, dvalid: 1'b0, chk_digit: 1'b0};
    blank_lz = 1'b1;
    pulse_load(16'h0042);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) scan_q.push_back(tbl[s]);
    prev = dsel;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      if (dsel === 4'b1110 && prev !== 4'b1110) found = 1'b1;
      prev = dsel;
    end
    if (!found) begin
      total++;
      $display("FAIL scan_align: dsel never entered 1110, last %b", dsel);
      scan_q.delete();
    end
    for (int j = 0; found && j < 16; j++) begin
      if (j > 0) @(posedge clk);
      e = scan_q.pop_front();
      total++; if (dsel !== e.dsel) $display("FAIL scan_dsel[%0d]: got %b want %b", j, dsel, e.dsel); else passed++;
      total++; if (dvalid !== e.dvalid) $display("FAIL scan_dvalid[%0d]: got %b want %b", j, dvalid, e.dvalid); else passed++;
      if (e.chk_digit) begin
        total++; if (digit !== e.digit) $display("FAIL scan_digit[%0d]: got %h want %h", j, digit, e.digit); else passed++;
      end
    end
    blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      total++; if (dvalid !== 1'b1) $display("FAIL noblank_dvalid[%0d]: got %b want 1", j, dvalid); else passed++;
      @(posedge clk);
    end
    blank_lz = 1'b1;
    pulse_clr();
    repeat (2) @(posedge clk);
    for (int j = 0; j < 16; j++) begin
      total++;
      if (dvalid !== (dsel === 4'b1110)) $display("FAIL zero_blank[%0d]: dvalid %b with dsel %b", j, dvalid, dsel);
      else passed++;
      @(posedge clk);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_hold;
    pulse_clr();
    run = 1'b1;
    repeat (7) @(posedge clk);
    run = 1'b0;
    repeat (20) @(posedge clk);
    total++; if (count !== 16'h0000) $display("FAIL hold_count: got %h want 0000", count); else passed++;
    run = 1'b1;
    repeat (2) @(posedge clk);
    total++; if (count !== 16'h0000) $display("FAIL hold_early_tick: got %h want 0000", count); else passed++;
    @(posedge clk);
    run = 1'b0;
    total++; if (count !== 16'h0001) $display("FAIL hold_resume_tick: got %h want 0001", count); else passed++;
  endtask

  task automatic test_reset_resume;
    pulse_load(16'h12A4);
    run = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    #1;
    total++; if (count !== 16'h0000) $display("FAIL async_rst_count: got %h want 0000", count); else passed++;
    total++; if (err !== 1'b0) $display("FAIL async_rst_err: got %b want 0", err); else passed++;
    total++; if (dsel !== 4'b1110) $display("FAIL async_rst_dsel: got %b want 1110", dsel); else passed++;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    total++; if (dsel !== 4'b1110) $display("FAIL resume_dsel0: got %b want 1110", dsel); else passed++;
    @(posedge clk);
    total++; if (dsel !== 4'b1101) $display("FAIL resume_dsel1: got %b want 1101", dsel); else passed++;
    repeat (4) @(posedge clk);
    total++; if (count !== 16'h0000) $display("FAIL resume_pre_tick: got %h want 0000", count); else passed++;
    @(posedge clk);
    run = 1'b0;
    total++; if (count !== 16'h0001) $display("FAIL resume_tick: got %h want 0001", count); else passed++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_bad_load();
    test_priority();
    test_scan();
    test_hold();
    test_reset_resume();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10: clk edges per count increment while running, legal range 2..65535.
REQ-002 The block SHALL have parameter SCAN_DIV, default 4: clk edges per display digit slot, legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port run, input, 1 bit: level; 1 = count, 0 = hold.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of count, prescaler and err.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-008 The block SHALL have port load_val, input, 16 bits: four BCD nibbles, [3:0] = least significant digit.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: 1 = blank leading zeros.
REQ-010 The block SHALL have port digit, output, 4 bits: BCD value of the digit currently scanned; feeds the 7-segment decoder data input.
REQ-011 The block SHALL have port dvalid, output, 1 bit: 1 = show digit, 0 = blank; feeds the decoder enable.
REQ-012 The block SHALL have port dsel, output, 4 bits: active-low one-hot digit select, bit n = digit n.
REQ-013 The block SHALL have port count, output, 16 bits: current 4-digit BCD count.
REQ-014 The block SHALL have port carry, output, 1 bit: one-cycle pulse when the count wraps from 9999 to 0000.
REQ-015 The block SHALL have port err, output, 1 bit: sticky flag marking a rejected load.

Function
REQ-016 Priority SHALL be clr > load > tick, evaluated each falling edge.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 while run=1 and no clr/load; reaching TICK_DIV-1 SHALL raise tick and wrap the prescaler to 0 on the same edge.
REQ-018 The prescaler SHALL hold its value while run=0; clr or load SHALL reset it to 0.
REQ-019 On tick, the count SHALL increment in BCD: a digit at 9 becomes 0 and carries into the next digit; no nibble SHALL ever hold a value of 10..15.
REQ-020 On tick at 9999, the count SHALL become 0000 and carry SHALL be 1 for exactly that one cycle; carry SHALL be 0 in all other cycles.
REQ-021 On clr, count SHALL be 0000, err 0, carry 0 at the next edge.
REQ-022 On load with every load_val nibble <= 9, count SHALL take load_val at the next edge.
REQ-023 On load with any nibble > 9, count SHALL be unchanged and err SHALL be set to 1; err SHALL stay 1 until clr or reset.
REQ-024 The scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of run; at its terminal value the digit index SHALL advance 0->1->2->3->0.
REQ-025 digit, dsel and dvalid SHALL be registered together from the current index and count, giving one cycle of latency after any index or count change.
REQ-026 dsel SHALL be ~(1<<index); exactly one dsel bit SHALL be 0 at all times.
REQ-027 With blank_lz=1, dvalid SHALL be 0 for any digit above the most significant nonzero digit; digit 0 SHALL never be blanked (0000 shows "0").
REQ-028 With blank_lz=0, dvalid SHALL always be 1.

Reset
REQ-029 While rst=0, the block SHALL hold: count=0000, prescaler=0, scan counter=0, index=0, digit=0, dsel=4'b1110, dvalid=1, carry=0, err=0.
REQ-030 Deasserting rst mid-scan or mid-count SHALL resume from the reset values on the first falling edge after rst=1.

Verification
REQ-031 Bench SHALL cover: TICK_DIV=10, run=1 from 0000 for 100 clk -> count=0010, carry never 1.
REQ-032 Bench SHALL cover: load 16'h9998, run=1 for 20 clk -> 9999 after the 1st tick, then 0000 with carry=1 for one cycle.
REQ-033 Bench SHALL cover: load 16'h12A4 -> count unchanged, err=1; then clr -> count=0000, err=0.
REQ-034 Bench SHALL cover: load and clr asserted together with load_val=16'h0042 -> count=0000.
REQ-035 Bench SHALL cover: count=0042, blank_lz=1, SCAN_DIV=4 -> dsel sequence 1110,1101,1011,0111 each held 4 clk; digit 2,4,x,x; dvalid 1,1,0,0.
REQ-036 Bench SHALL cover: run=1 for 7 clk, run=0 for 20 clk, run=1 -> first tick after 3 more clk (prescaler held at 7).
